// File: rtl/zipdma_pkg.sv
// -----------------------------------------------------------------------------
// zipdma_pkg
// Shared definitions for the ZipDMA transfer sequencer:
//   - state_e   : sequencer state encoding (S_IDLE .. S_ABORT)
//   - max_chunk : largest chunk in bytes for a given log2 chunk size
// -----------------------------------------------------------------------------
package zipdma_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_XFER  = 3'd3,
    S_ABORT = 3'd4
  } state_e;

  // Largest chunk the engines accept: 2^lgmemlen bytes.
  function automatic int unsigned max_chunk(input int unsigned lgmemlen);
    return 32'd1 << lgmemlen;
  endfunction

endpackage

// File: rtl/zipdma_fsm.sv
// -----------------------------------------------------------------------------
// zipdma_fsm
// Transfer sequencer behind the ZipDMA control registers. Takes one programmed
// request (src, dst, total length, chunk length), splits it into chunks and
// issues each chunk to the MM2S (read) and S2MM (write) engines whenever the
// trigger allows. Reports busy, error, live addresses and remaining length.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_request, i_abort        start (level, held until o_busy) / abort (level)
//   i_src_addr, i_dst_addr    start addresses
//   i_length                  total bytes
//   i_transferlen             max chunk bytes ({1,0..0} = 2^LGMEMLEN)
//   i_mm2s_inc, i_s2mm_inc    address increments between chunks
//   i_trigger                 chunk may start
//   o_busy, o_err             transfer in progress / one-cycle error pulse
//   o_current_src/dst         next chunk addresses
//   o_remaining_len           bytes not yet transferred
//   o_chunk_len               length of the current chunk
//   o_mm2s/s2mm_request       one-cycle chunk start to the engines
//   o_engine_abort            abort to both engines
//   i_mm2s/s2mm_busy, _err    engine status (busy registered, high the cycle
//                             after a request)
// -----------------------------------------------------------------------------
module zipdma_fsm
  import zipdma_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 30,
  parameter int LGMEMLEN      = 10,
  parameter int LGDMALENGTH   = ADDRESS_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_request,
  input  logic                     i_abort,
  input  logic [ADDRESS_WIDTH-1:0] i_src_addr,
  input  logic [ADDRESS_WIDTH-1:0] i_dst_addr,
  input  logic [LGDMALENGTH-1:0]   i_length,
  input  logic [LGMEMLEN:0]        i_transferlen,
  input  logic                     i_mm2s_inc,
  input  logic                     i_s2mm_inc,
  input  logic                     i_trigger,
  output logic                     o_busy,
  output logic                     o_err,
  output logic [ADDRESS_WIDTH-1:0] o_current_src,
  output logic [ADDRESS_WIDTH-1:0] o_current_dst,
  output logic [LGDMALENGTH-1:0]   o_remaining_len,
  output logic [LGMEMLEN:0]        o_chunk_len,
  output logic                     o_mm2s_request,
  output logic                     o_s2mm_request,
  output logic                     o_engine_abort,
  input  logic                     i_mm2s_busy,
  input  logic                     i_mm2s_err,
  input  logic                     i_s2mm_busy,
  input  logic                     i_s2mm_err
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int LW = LGDMALENGTH;
  localparam int TW = LGMEMLEN + 1;
  localparam int CW = (LW > TW) ? LW : TW;
  localparam logic [TW-1:0] MAX_CHUNK = TW'(max_chunk(LGMEMLEN));

  state_e         state_r, state_s;
  logic           busy_r, busy_s;
  logic           err_r, err_s;
  logic           req_r, req_s;
  logic           abort_r, abort_s;
  logic [AW-1:0]  src_r, src_s;
  logic [AW-1:0]  dst_r, dst_s;
  logic [LW-1:0]  rem_r, rem_s;
  logic [TW-1:0]  chunk_r, chunk_s;
  logic           mm2s_inc_r, mm2s_inc_s;
  logic           s2mm_inc_r, s2mm_inc_s;

  logic [TW-1:0]  tlen_s;
  logic [CW-1:0]  rem_ext_s;
  logic [CW-1:0]  tlen_ext_s;
  logic [TW-1:0]  min_len_s;
  logic [LW-1:0]  rem_next_s;
  logic           any_err_s;
  logic           eng_idle_s;

  // Chunk lengths beyond the engine maximum are clamped to it.
  assign tlen_s     = (i_transferlen > MAX_CHUNK) ? MAX_CHUNK : i_transferlen;
  assign rem_ext_s  = CW'(rem_r);
  assign tlen_ext_s = CW'(tlen_s);
  assign rem_next_s = rem_r - LW'(chunk_r);
  assign any_err_s  = i_mm2s_err || i_s2mm_err;
  // A request still on the wire means the engines have not yet raised busy,
  // so they must not be considered idle in that cycle.
  assign eng_idle_s = !req_r && !i_mm2s_busy && !i_s2mm_busy;

  // Chunk length: the smaller of what is left and the chunk limit.
  always_comb begin
    min_len_s = tlen_s;
    if (rem_ext_s < tlen_ext_s) begin
      min_len_s = rem_ext_s[TW-1:0];
    end else begin
      min_len_s = tlen_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s    = state_r;
    busy_s     = busy_r;
    err_s      = 1'b0;
    req_s      = 1'b0;
    abort_s    = abort_r;
    src_s      = src_r;
    dst_s      = dst_r;
    rem_s      = rem_r;
    chunk_s    = chunk_r;
    mm2s_inc_s = mm2s_inc_r;
    s2mm_inc_s = s2mm_inc_r;

    case (state_r)
      S_IDLE: begin
        abort_s = 1'b0;
        if (i_request && !i_abort) begin
          src_s      = i_src_addr;
          dst_s      = i_dst_addr;
          rem_s      = i_length;
          mm2s_inc_s = i_mm2s_inc;
          s2mm_inc_s = i_s2mm_inc;
          busy_s     = 1'b1;
          state_s    = S_WAIT;
        end else begin
          busy_s  = 1'b0;
          state_s = S_IDLE;
        end
      end

      S_WAIT: begin
        if (any_err_s) begin
          err_s   = 1'b1;
          abort_s = 1'b1;
          state_s = S_ABORT;
        end else if (i_abort) begin
          busy_s  = 1'b0;
          state_s = S_IDLE;
        end else if (rem_r == {LW{1'b0}}) begin
          // Zero-length request, or nothing left: nothing to issue.
          busy_s  = 1'b0;
          state_s = S_IDLE;
        end else if (i_trigger) begin
          chunk_s = min_len_s;
          state_s = S_START;
        end else begin
          state_s = S_WAIT;
        end
      end

      S_START: begin
        if (any_err_s) begin
          err_s   = 1'b1;
          abort_s = 1'b1;
          state_s = S_ABORT;
        end else if (i_abort) begin
          abort_s = 1'b1;
          state_s = S_ABORT;
        end else begin
          req_s   = 1'b1;
          state_s = S_XFER;
        end
      end

      S_XFER: begin
        if (any_err_s) begin
          // Error beats a simultaneous chunk-done: counters stay frozen.
          err_s   = 1'b1;
          abort_s = 1'b1;
          state_s = S_ABORT;
        end else if (i_abort) begin
          abort_s = 1'b1;
          state_s = S_ABORT;
        end else if (eng_idle_s) begin
          rem_s = rem_next_s;
          if (mm2s_inc_r) begin
            src_s = src_r + AW'(chunk_r);
          end else begin
            src_s = src_r;
          end
          if (s2mm_inc_r) begin
            dst_s = dst_r + AW'(chunk_r);
          end else begin
            dst_s = dst_r;
          end
          if (rem_next_s == {LW{1'b0}}) begin
            busy_s  = 1'b0;
            state_s = S_IDLE;
          end else begin
            state_s = S_WAIT;
          end
        end else begin
          state_s = S_XFER;
        end
      end

      S_ABORT: begin
        // Already unwinding an error/abort: further engine errors add no pulse.
        if (eng_idle_s) begin
          abort_s = 1'b0;
          busy_s  = 1'b0;
          state_s = S_IDLE;
        end else begin
          abort_s = 1'b1;
          state_s = S_ABORT;
        end
      end

      default: begin
        busy_s  = 1'b0;
        abort_s = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
      req_r      <= 1'b0;
      abort_r    <= 1'b0;
      src_r      <= {AW{1'b0}};
      dst_r      <= {AW{1'b0}};
      rem_r      <= {LW{1'b0}};
      chunk_r    <= {TW{1'b0}};
      mm2s_inc_r <= 1'b0;
      s2mm_inc_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy_r     <= busy_s;
      err_r      <= err_s;
      req_r      <= req_s;
      abort_r    <= abort_s;
      src_r      <= src_s;
      dst_r      <= dst_s;
      rem_r      <= rem_s;
      chunk_r    <= chunk_s;
      mm2s_inc_r <= mm2s_inc_s;
      s2mm_inc_r <= s2mm_inc_s;
    end
  end

  assign o_busy          = busy_r;
  assign o_err           = err_r;
  assign o_mm2s_request  = req_r;
  assign o_s2mm_request  = req_r;
  assign o_engine_abort  = abort_r;
  assign o_current_src   = src_r;
  assign o_current_dst   = dst_r;
  assign o_remaining_len = rem_r;
  assign o_chunk_len     = chunk_r;

endmodule

// File: tb/tb_zipdma_fsm.sv
// -----------------------------------------------------------------------------
// tb_zipdma_fsm
// Directed bench for zipdma_fsm. A reference chunk planner pushes the expected
// (src, dst, remaining, chunk length) of every chunk onto a scoreboard; a
// monitor pops and compares one entry per engine request. Simple counting
// engine models supply registered busy responses.
// -----------------------------------------------------------------------------
module tb_zipdma_fsm;

  localparam int AW = 30;
  localparam int LW = 30;
  localparam int TW = 11;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_request;
  logic          i_abort;
  logic [AW-1:0] i_src_addr;
  logic [AW-1:0] i_dst_addr;
  logic [LW-1:0] i_length;
  logic [TW-1:0] i_transferlen;
  logic          i_mm2s_inc;
  logic          i_s2mm_inc;
  logic          i_trigger;
  logic          o_busy;
  logic          o_err;
  logic [AW-1:0] o_current_src;
  logic [AW-1:0] o_current_dst;
  logic [LW-1:0] o_remaining_len;
  logic [TW-1:0] o_chunk_len;
  logic          o_mm2s_request;
  logic          o_s2mm_request;
  logic          o_engine_abort;
  logic          i_mm2s_busy;
  logic          i_mm2s_err;
  logic          i_s2mm_busy;
  logic          i_s2mm_err;

  zipdma_fsm #(.ADDRESS_WIDTH(AW), .LGMEMLEN(10), .LGDMALENGTH(LW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_request(i_request), .i_abort(i_abort),
    .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_length(i_length),
    .i_transferlen(i_transferlen), .i_mm2s_inc(i_mm2s_inc), .i_s2mm_inc(i_s2mm_inc),
    .i_trigger(i_trigger), .o_busy(o_busy), .o_err(o_err),
    .o_current_src(o_current_src), .o_current_dst(o_current_dst),
    .o_remaining_len(o_remaining_len), .o_chunk_len(o_chunk_len),
    .o_mm2s_request(o_mm2s_request), .o_s2mm_request(o_s2mm_request),
    .o_engine_abort(o_engine_abort), .i_mm2s_busy(i_mm2s_busy),
    .i_mm2s_err(i_mm2s_err), .i_s2mm_busy(i_s2mm_busy), .i_s2mm_err(i_s2mm_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] rem;
    logic [TW-1:0] len;
  } chunk_t;

  chunk_t sb[$];
  chunk_t mon_exp;
  int     vectors     = 0;
  int     miscompares = 0;
  int     req_count   = 0;
  int     err_count   = 0;

  // Engine models: busy rises the cycle after a request, lasts a fixed time.
  logic [3:0] mm_cnt = 4'd0;
  logic [3:0] s2_cnt = 4'd0;
  always @(posedge i_clk) begin
    if (o_mm2s_request) mm_cnt <= 4'd3;
    else if (mm_cnt != 4'd0) mm_cnt <= mm_cnt - 4'd1;
    if (o_s2mm_request) s2_cnt <= 4'd5;
    else if (s2_cnt != 4'd0) s2_cnt <= s2_cnt - 4'd1;
  end
  assign i_mm2s_busy = (mm_cnt != 4'd0);
  assign i_s2mm_busy = (s2_cnt != 4'd0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every engine request must match the next scoreboard entry.
  always @(negedge i_clk) begin
    if (o_err) err_count++;
    if (o_mm2s_request || o_s2mm_request) begin
      req_count++;
      chk("mm2s_req", {63'd0, o_mm2s_request}, 64'd1);
      chk("s2mm_req", {63'd0, o_s2mm_request}, 64'd1);
      chk("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("chunk_src", {34'd0, o_current_src}, {34'd0, mon_exp.src});
        chk("chunk_dst", {34'd0, o_current_dst}, {34'd0, mon_exp.dst});
        chk("chunk_rem", {34'd0, o_remaining_len}, {34'd0, mon_exp.rem});
        chk("chunk_len", {53'd0, o_chunk_len}, {53'd0, mon_exp.len});
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference planner: expected chunk sequence for a whole request.
  task automatic plan(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l,
                      input logic [TW-1:0] t, input logic mi, input logic si,
                      output logic [AW-1:0] fs, output logic [AW-1:0] fd);
    logic [LW-1:0] rem;
    logic [AW-1:0] cs;
    logic [AW-1:0] cd;
    logic [LW-1:0] cl;
    rem = l; cs = s; cd = d;
    while (rem != '0) begin
      cl = (rem < {19'd0, t}) ? rem : {19'd0, t};
      sb.push_back({cs, cd, rem, cl[TW-1:0]});
      rem = rem - cl;
      if (mi) cs = cs + cl;
      if (si) cd = cd + cl;
    end
    fs = cs; fd = cd;
  endtask

  task automatic push1(input logic [AW-1:0] s, input logic [AW-1:0] d,
                       input logic [LW-1:0] r, input logic [TW-1:0] l);
    sb.push_back({s, d, r, l});
  endtask

  task automatic start_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l,
                            input logic [TW-1:0] t, input logic mi, input logic si);
    i_src_addr = s; i_dst_addr = d; i_length = l; i_transferlen = t;
    i_mm2s_inc = mi; i_s2mm_inc = si; i_request = 1'b1;
    tick();
    chk("busy_after_request", {63'd0, o_busy}, 64'd1);
    i_request = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 400) begin tick(); n++; end
    chk(tag, {63'd0, o_busy}, 64'd0);
  endtask

  task automatic wait_reqs(input int target, input string tag);
    int n;
    n = 0;
    while (req_count < target && n < 400) begin tick(); n++; end
    chk(tag, req_count, target);
  endtask

  task automatic wait_engines(input string tag);
    int n;
    n = 0;
    while ((i_mm2s_busy || i_s2mm_busy) && n < 100) begin tick(); n++; end
    chk(tag, {63'd0, i_mm2s_busy || i_s2mm_busy}, 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  {63'd0, o_busy}, 64'd0);
    chk({tag, "_err"},   {63'd0, o_err}, 64'd0);
    chk({tag, "_mreq"},  {63'd0, o_mm2s_request}, 64'd0);
    chk({tag, "_sreq"},  {63'd0, o_s2mm_request}, 64'd0);
    chk({tag, "_abort"}, {63'd0, o_engine_abort}, 64'd0);
    chk({tag, "_src"},   {34'd0, o_current_src}, 64'd0);
    chk({tag, "_dst"},   {34'd0, o_current_dst}, 64'd0);
    chk({tag, "_rem"},   {34'd0, o_remaining_len}, 64'd0);
    chk({tag, "_chunk"}, {53'd0, o_chunk_len}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] fs;
    logic [AW-1:0] fd;
    int base;
    int ebase;

    i_reset = 1'b1; i_request = 1'b0; i_abort = 1'b0; i_src_addr = '0; i_dst_addr = '0;
    i_length = '0; i_transferlen = '0; i_mm2s_inc = 1'b0; i_s2mm_inc = 1'b0;
    i_trigger = 1'b0; i_mm2s_err = 1'b0; i_s2mm_err = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    i_reset = 1'b0;
    tick();

    // Three equal chunks, both addresses incrementing, trigger tied high.
    i_trigger = 1'b1;
    base = req_count;
    plan(30'h100, 30'h800, 30'h30, 11'h10, 1'b1, 1'b1, fs, fd);
    start_xfer(30'h100, 30'h800, 30'h30, 11'h10, 1'b1, 1'b1);
    wait_reqs(base + 3, "t1_three_chunks");
    wait_engines("t1_engines_idle");
    chk("t1_busy_at_last_done", {63'd0, o_busy}, 64'd1);
    tick();
    chk("t1_busy_drop", {63'd0, o_busy}, 64'd0);
    chk("t1_src", {34'd0, o_current_src}, 64'h130);
    chk("t1_dst", {34'd0, o_current_dst}, 64'h830);
    chk("t1_rem", {34'd0, o_remaining_len}, 64'h0);
    chk("t1_no_err", err_count, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // Uneven length: 0x10, 0x10, 0x05.
    plan(30'h200, 30'h900, 30'h25, 11'h10, 1'b1, 1'b1, fs, fd);
    start_xfer(30'h200, 30'h900, 30'h25, 11'h10, 1'b1, 1'b1);
    wait_idle("t2_done");
    chk("t2_src", {34'd0, o_current_src}, 64'h225);
    chk("t2_rem", {34'd0, o_remaining_len}, 64'h0);
    chk("t2_last_chunk", {53'd0, o_chunk_len}, 64'h5);
    chk("t2_sb_empty", sb.size(), 0);

    // Source fixed, destination incrementing.
    plan(30'h100, 30'h800, 30'h20, 11'h10, 1'b0, 1'b1, fs, fd);
    start_xfer(30'h100, 30'h800, 30'h20, 11'h10, 1'b0, 1'b1);
    wait_idle("t3_done");
    chk("t3_src", {34'd0, o_current_src}, 64'h100);
    chk("t3_dst", {34'd0, o_current_dst}, 64'h820);
    chk("t3_sb_empty", sb.size(), 0);

    // Trigger gating and trigger-to-request latency.
    i_trigger = 1'b0;
    base = req_count;
    plan(30'h300, 30'hA00, 30'h10, 11'h10, 1'b1, 1'b1, fs, fd);
    start_xfer(30'h300, 30'hA00, 30'h10, 11'h10, 1'b1, 1'b1);
    repeat (20) tick();
    chk("t4_no_req_without_trigger", req_count, base);
    chk("t4_still_busy", {63'd0, o_busy}, 64'd1);
    i_trigger = 1'b1;
    tick();
    chk("t4_req_at_1", {63'd0, o_mm2s_request}, 64'd0);
    tick();
    chk("t4_req_at_2", {63'd0, o_mm2s_request}, 64'd1);
    tick();
    chk("t4_req_at_3", {63'd0, o_mm2s_request}, 64'd0);
    wait_idle("t4_done");
    chk("t4_sb_empty", sb.size(), 0);

    // Abort in the wait state, together with trigger: abort wins.
    i_trigger = 1'b0;
    base = req_count;
    start_xfer(30'h100, 30'h800, 30'h20, 11'h10, 1'b1, 1'b1);
    i_abort = 1'b1; i_trigger = 1'b1;
    tick();
    chk("t4_abort_busy_low", {63'd0, o_busy}, 64'd0);
    i_abort = 1'b0; i_trigger = 1'b0;
    repeat (3) tick();
    chk("t4_abort_no_req", req_count, base);
    chk("t4_abort_no_engine_abort", {63'd0, o_engine_abort}, 64'd0);

    // Zero-length request: busy for one cycle, nothing issued.
    i_trigger = 1'b1;
    start_xfer(30'h100, 30'h800, 30'h0, 11'h10, 1'b1, 1'b1);
    tick();
    chk("zero_len_busy_low", {63'd0, o_busy}, 64'd0);
    repeat (3) tick();
    chk("zero_len_no_req", req_count, base);

    // Write-engine error during the second chunk.
    base = req_count;
    ebase = err_count;
    push1(30'h100, 30'h800, 30'h30, 11'h10);
    push1(30'h110, 30'h810, 30'h20, 11'h10);
    start_xfer(30'h100, 30'h800, 30'h30, 11'h10, 1'b1, 1'b1);
    wait_reqs(base + 2, "t5_second_chunk");
    i_s2mm_err = 1'b1;
    tick();
    chk("t5_err_pulse", {63'd0, o_err}, 64'd1);
    chk("t5_busy_during_err", {63'd0, o_busy}, 64'd1);
    chk("t5_engine_abort", {63'd0, o_engine_abort}, 64'd1);
    i_s2mm_err = 1'b0;
    tick();
    chk("t5_err_single", {63'd0, o_err}, 64'd0);
    chk("t5_abort_held", {63'd0, o_engine_abort}, 64'd1);
    wait_engines("t5_engines_idle");
    chk("t5_abort_until_idle", {63'd0, o_engine_abort}, 64'd1);
    tick();
    chk("t5_busy_low", {63'd0, o_busy}, 64'd0);
    chk("t5_abort_low", {63'd0, o_engine_abort}, 64'd0);
    chk("t5_rem", {34'd0, o_remaining_len}, 64'h20);
    chk("t5_src", {34'd0, o_current_src}, 64'h110);
    chk("t5_dst", {34'd0, o_current_dst}, 64'h810);
    chk("t5_err_count", err_count - ebase, 1);
    chk("t5_sb_empty", sb.size(), 0);

    // Source address wrap modulo 2^30.
    plan(30'h3FFFFFF0, 30'h0, 30'h20, 11'h10, 1'b1, 1'b1, fs, fd);
    start_xfer(30'h3FFFFFF0, 30'h0, 30'h20, 11'h10, 1'b1, 1'b1);
    wait_idle("t6_done");
    chk("t6_src_wrap", {34'd0, o_current_src}, 64'h10);
    chk("t6_dst", {34'd0, o_current_dst}, 64'h20);
    chk("t6_sb_empty", sb.size(), 0);

    // Full-size chunk encoding ({1,0..0} = 1024 bytes).
    plan(30'h1000, 30'h2000, 30'h500, 11'h400, 1'b1, 1'b1, fs, fd);
    start_xfer(30'h1000, 30'h2000, 30'h500, 11'h400, 1'b1, 1'b1);
    wait_idle("t7_done");
    chk("t7_src", {34'd0, o_current_src}, 64'h1500);
    chk("t7_last_chunk", {53'd0, o_chunk_len}, 64'h100);
    chk("t7_sb_empty", sb.size(), 0);

    // Reset in the middle of a chunk.
    base = req_count;
    push1(30'h100, 30'h800, 30'h30, 11'h10);
    start_xfer(30'h100, 30'h800, 30'h30, 11'h10, 1'b1, 1'b1);
    wait_reqs(base + 1, "t8_first_chunk");
    i_reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    i_reset = 1'b0;
    wait_engines("t8_engines_idle");
    repeat (3) tick();
    chk("t8_stays_idle", {63'd0, o_busy}, 64'd0);
    chk("t8_no_more_req", req_count, base + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/zipdma_fsm.md
Name: zipdma_fsm

Overview:
- Transfer sequencer directly downstream of the ZipDMA control-register block.
- Takes one programmed DMA request: source, destination, total length, per-chunk transfer length and trigger.
- Splits the request into chunks of at most transfer length and issues each chunk to the MM2S (read) and S2MM (write) engines, gated by the trigger.
- Reports busy, error, live addresses and remaining length back to the control block.

Parameters:
- ADDRESS_WIDTH, 30: byte address width (AW).
- LGMEMLEN, 10: log2 of the maximum chunk size in bytes.
- LGDMALENGTH, ADDRESS_WIDTH: width of total length and remaining length.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  1  start request, level, held until o_busy is seen.
- i_abort  in  1  abort request, level.
- i_src_addr  in  AW  start source address.
- i_dst_addr  in  AW  start destination address.
- i_length  in  LGDMALENGTH  total bytes.
- i_transferlen  in  LGMEMLEN+1  max chunk bytes; {1,0...} = 2^LGMEMLEN.
- i_mm2s_inc  in  1  source address increments between chunks.
- i_s2mm_inc  in  1  destination address increments between chunks.
- i_trigger  in  1  chunk may start.
- o_busy  out  1  transfer in progress.
- o_err  out  1  error pulse.
- o_current_src  out  AW  next chunk source address.
- o_current_dst  out  AW  next chunk destination address.
- o_remaining_len  out  LGDMALENGTH  bytes not yet transferred.
- o_chunk_len  out  LGMEMLEN+1  length of the current chunk.
- o_mm2s_request  out  1  one-cycle chunk start to the read engine.
- o_s2mm_request  out  1  one-cycle chunk start to the write engine.
- o_engine_abort  out  1  abort to both engines.
- i_mm2s_busy  in  1  read engine busy; registered, high the cycle after a request.
- i_mm2s_err  in  1  read engine bus error.
- i_s2mm_busy  in  1  write engine busy; registered, high the cycle after a request.
- i_s2mm_err  in  1  write engine bus error.

Behaviour:
- Reset: state S_IDLE. Outputs o_busy, o_err, o_mm2s_request, o_s2mm_request, o_engine_abort, o_current_src, o_current_dst, o_remaining_len and o_chunk_len all reset to 0. Reset mid-transfer returns to S_IDLE next cycle regardless of engine state.
- States: S_IDLE, S_WAIT, S_START, S_XFER, S_ABORT.
- S_IDLE: on i_request && !i_abort:
  - Latch src, dst, length and inc flags; o_busy<=1.
  - Go to S_WAIT, or to S_IDLE with o_busy<=0 the next cycle if i_length==0.
- S_WAIT:
  - i_abort -> S_IDLE, o_busy<=0; no engine activity.
  - Else if i_trigger -> S_START, o_chunk_len <= min(o_remaining_len, i_transferlen), zero-extended compare.
- S_START: o_mm2s_request and o_s2mm_request high for exactly this one cycle. Next state S_XFER.
- S_XFER: chunk is done when !i_mm2s_busy && !i_s2mm_busy. On done, the same cycle registers:
  - o_remaining_len -= o_chunk_len.
  - o_current_src += o_chunk_len if the mm2s inc flag is set, else unchanged.
  - o_current_dst += o_chunk_len if the s2mm inc flag is set, else unchanged.
  - Addresses wrap modulo 2^AW.
  - Next state: S_IDLE with o_busy<=0 if the new remaining is 0, else S_WAIT.
- Errors: i_mm2s_err or i_s2mm_err in any non-idle state:
  - o_err=1 for exactly one cycle; o_busy stays high that cycle; go to S_ABORT.
  - Counters freeze at their last completed-chunk values.
- i_abort in S_START or S_XFER: go to S_ABORT; no o_err.
- S_ABORT:
  - o_engine_abort held high.
  - Wait until both engine busy inputs are low, then o_engine_abort<=0, o_busy<=0, go to S_IDLE.
- Simultaneous events:
  - Error and chunk-done in the same cycle: error wins; counters are not updated.
  - Abort and trigger in S_WAIT: abort wins.
  - i_request while busy: ignored.
- Latency:
  - Request to o_busy: 1 cycle.
  - Trigger in S_WAIT to engine request: 2 cycles.
  - Final engine-done to o_busy low: 1 cycle.

Decomposition:
- Package zipdma_pkg:
  - State encoding localparams for S_IDLE..S_ABORT.
  - Helper constant for max chunk, 1<<LGMEMLEN.
- No sub-module needed. The min/chunk computation is inline, single file.

Test Plan:
- src=0x100, dst=0x800, len=0x30, tlen=0x10, inc both, trigger tied high -> three chunks of 0x10. current_src reads 0x110/0x120/0x130 after each chunk. Busy drops 1 cycle after the third done. o_err never asserted.
- len=0x25, tlen=0x10 -> chunk lengths 0x10, 0x10, 0x05; remaining_len reaches 0.
- mm2s_inc=0, s2mm_inc=1, len=0x20, tlen=0x10 -> current_src stays 0x100; current_dst 0x800 -> 0x810 -> 0x820.
- Trigger low for 20 cycles in S_WAIT -> no engine request; trigger high -> request exactly 2 cycles later. Abort asserted in S_WAIT -> busy low next cycle, no requests.
- i_s2mm_err during the second chunk of len=0x30 -> o_err single-cycle pulse. o_engine_abort held until both engines idle, then busy low. remaining_len=0x20, current_src=0x110.
- AW=30, src=0x3FFFFFF0, len=0x20, tlen=0x10 -> current_src wraps 0x3FFFFFF0 -> 0x00000000 -> 0x00000010. Reset asserted mid-S_XFER -> all outputs 0 the next cycle.
